// File: rtl/irrigation_scheduler.sv
`default_nettype none
// ============================================================================
// Module : irrigation_scheduler
// Round-robin irrigation valve scheduler with per-zone dryness debounce.
// Rev    : 1.0  initial release
// ============================================================================
module irrigation_scheduler #(
    parameter int ZONES       = 4,
    parameter int WATER_TIME  = 8,
    parameter int SETTLE_TIME = 2,
    parameter int DEB         = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_enable,
    input  logic [ZONES-1:0]         i_dry,
    output logic [ZONES-1:0]         o_valve,
    output logic [$clog2(ZONES)-1:0] o_active_zone,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int c_ZW   = $clog2(ZONES);
    localparam int c_SW   = c_ZW + 1;
    localparam int c_CW   = $clog2(DEB + 1);
    localparam int c_TMAX = (WATER_TIME > SETTLE_TIME) ? WATER_TIME : SETTLE_TIME;
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_CW-1:0] c_DEB   = c_CW'(DEB);
    localparam logic [c_TW-1:0] c_WLOAD = c_TW'(WATER_TIME - 1);
    localparam logic [c_TW-1:0] c_SLOAD = c_TW'(SETTLE_TIME - 1);
    localparam logic [c_ZW-1:0] c_ZLAST = c_ZW'(ZONES - 1);
    localparam logic [c_SW-1:0] c_ZN    = c_SW'(ZONES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WATER  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ZONES-1:0]   r_valve, w_valve_nxt;
    logic [c_ZW-1:0]    r_zone, w_zone_nxt;
    logic [c_ZW-1:0]    r_rr, w_rr_nxt;
    logic [c_ZW-1:0]    w_sel;
    logic [c_SW-1:0]    w_sum;
    logic [c_TW-1:0]    r_timer, w_timer_nxt;
    logic               r_busy, r_done, w_done_nxt, w_found;
    logic [ZONES-1:0]   w_req, w_clr, w_rot;
    logic [2*ZONES-1:0] w_dbl;
    logic [c_CW-1:0]    r_cnt [ZONES];

    // A completion clear overrides a simultaneous dry sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ZONES; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < ZONES; i++) begin
                if (w_clr[i] || !i_dry[i])
                    r_cnt[i] <= '0;
                else if (r_cnt[i] != c_DEB)
                    r_cnt[i] <= r_cnt[i] + c_CW'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < ZONES; g++) begin : g_req
            assign w_req[g] = (r_cnt[g] == c_DEB);
        end
    endgenerate

    // Rotate requests so bit 0 is the pointer position, then pick the lowest.
    assign w_dbl = {w_req, w_req} >> r_rr;
    assign w_rot = w_dbl[ZONES-1:0];

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < ZONES; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr} + c_SW'(k);
            end
        end
        if (w_sum >= c_ZN) w_sum = w_sum - c_ZN;
        w_sel = w_sum[c_ZW-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valve_nxt = r_valve;
        w_zone_nxt  = r_zone;
        w_rr_nxt    = r_rr;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        w_clr       = '0;
        case (r_state)
            S_IDLE: begin
                w_valve_nxt = '0;
                if (i_enable && w_found) begin
                    w_state_nxt        = S_WATER;
                    w_valve_nxt[w_sel] = 1'b1;
                    w_zone_nxt         = w_sel;
                    w_timer_nxt        = c_WLOAD;
                end
            end
            S_WATER: begin
                if (!i_enable) begin
                    w_state_nxt = S_SETTLE;
                    w_valve_nxt = '0;
                    w_timer_nxt = c_SLOAD;
                end else if (r_timer == '0) begin
                    w_state_nxt   = S_SETTLE;
                    w_valve_nxt   = '0;
                    w_timer_nxt   = c_SLOAD;
                    w_done_nxt    = 1'b1;
                    w_rr_nxt      = (r_zone == c_ZLAST) ? '0 : r_zone + c_ZW'(1);
                    w_clr[r_zone] = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - c_TW'(1);
                end
            end
            S_SETTLE: begin
                if (r_timer == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_timer_nxt = r_timer - c_TW'(1);
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valve_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valve <= '0;
            r_zone  <= '0;
            r_rr    <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valve <= w_valve_nxt;
            r_zone  <= w_zone_nxt;
            r_rr    <= w_rr_nxt;
            r_timer <= w_timer_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign o_valve       = r_valve;
    assign o_active_zone = r_zone;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_irrigation_scheduler
// Directed and randomized checks of irrigation_scheduler against a model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_irrigation_scheduler;
    localparam int c_ZONES = 4;
    localparam int c_WT    = 8;
    localparam int c_ST    = 2;
    localparam int c_DEB   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] dry = 4'b0;
    logic [3:0] valve;
    logic [1:0] active_zone;
    logic       busy;
    logic       done;

    irrigation_scheduler #(
        .ZONES(c_ZONES), .WATER_TIME(c_WT), .SETTLE_TIME(c_ST), .DEB(c_DEB)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_dry(dry),
        .o_valve(valve), .o_active_zone(active_zone), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: dry streak lengths, remaining open/settle cycles, pointer.
    int m_streak [c_ZONES];
    int m_rr, m_zone, m_wleft, m_sleft;
    bit m_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < c_ZONES; i++) m_streak[i] = 0;
        m_rr = 0; m_zone = 0; m_wleft = 0; m_sleft = 0; m_done = 0;
    endfunction

    function automatic void m_step(input logic [3:0] d, input logic e);
        int clear_zone;
        bit found;
        clear_zone = -1;
        m_done = 0;
        if (m_wleft > 0) begin
            if (!e) begin
                m_wleft = 0; m_sleft = c_ST;
            end else if (m_wleft == 1) begin
                m_wleft = 0; m_sleft = c_ST; m_done = 1;
                m_rr = (m_zone + 1) % c_ZONES;
                clear_zone = m_zone;
            end else begin
                m_wleft--;
            end
        end else if (m_sleft > 0) begin
            m_sleft--;
        end else if (e) begin
            found = 0;
            for (int k = 0; k < c_ZONES; k++) begin
                int z;
                z = (m_rr + k) % c_ZONES;
                if (!found && m_streak[z] >= c_DEB) begin
                    found = 1; m_zone = z; m_wleft = c_WT;
                end
            end
        end
        for (int i = 0; i < c_ZONES; i++) begin
            if (d[i] && m_streak[i] < 1000) m_streak[i]++;
            else if (!d[i]) m_streak[i] = 0;
            if (i == clear_zone) m_streak[i] = 0;
        end
    endfunction

    task automatic compare_all();
        logic [3:0] ev;
        ev = (m_wleft > 0) ? (4'b0001 << m_zone) : 4'b0000;
        check_val("valve", valve, ev);
        check_val("active_zone", active_zone, m_zone);
        check_val("busy", busy, (m_wleft > 0) || (m_sleft > 0));
        check_val("done", done, m_done);
    endtask

    // Called at a falling edge: drive, clock, then compare at the next falling edge.
    task automatic cyc(input logic [3:0] d, input logic e);
        dry = d; enable = e;
        @(posedge clk);
        m_step(d, e);
        @(negedge clk);
        compare_all();
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic async_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        compare_all();
        repeat (hold) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    int         vcnt, dcnt, n, tmo;
    bit         seen;
    logic [3:0] prev, rd;
    logic       re;
    int         order [$];
    int         exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        m_reset();
        dry = 4'hF; enable = 1'b1; rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            compare_all();
        end
        rst_n = 1'b1;

        // Single dry zone: opens after the 4th edge for WATER_TIME cycles.
        vcnt = 0; dcnt = 0;
        for (int c = 0; c < 14; c++) begin
            cyc(4'b0010, 1'b1);
            if (valve == 4'b0010) vcnt++;
            if (done) dcnt++;
            if (c == 3) check_val("first_open", valve, 4'b0010);
        end
        check_val("open_cycles", vcnt, c_WT);
        check_val("done_pulses", dcnt, 1);
        check_val("busy_after_settle", busy, 0);
        repeat (4) cyc(4'b0000, 1'b1);

        // Short glitch never reaches the debounce threshold.
        seen = 0;
        repeat (2) cyc(4'b0001, 1'b1);
        repeat (6) begin
            cyc(4'b0000, 1'b1);
            if (busy || valve != 0) seen = 1;
        end
        check_val("glitch_ignored", seen, 0);

        // Abort zone 1 on its 4th watering cycle; it must be chosen again.
        async_reset(1);
        tmo = 0;
        while (valve == 0 && tmo < 20) begin
            cyc(4'b1110, 1'b1);
            tmo++;
        end
        check_val("abort_zone", active_zone, 1);
        repeat (3) cyc(4'b1110, 1'b1);
        cyc(4'b1110, 1'b0);
        check_val("abort_valve", valve, 0);
        check_val("abort_done", done, 0);
        cyc(4'b1110, 1'b0);
        cyc(4'b1110, 1'b0);
        check_val("abort_idle", busy, 0);
        cyc(4'b1110, 1'b1);
        check_val("reselect_zone", active_zone, 1);
        check_val("reselect_valve", valve, 4'b0010);

        // Reset mid-watering, then debounce restarts and the valve reopens on edge 4.
        repeat (3) cyc(4'b1111, 1'b1);
        async_reset(2);
        n = 0;
        while (valve == 0 && n < 20) begin
            cyc(4'b1111, 1'b1);
            n++;
        end
        check_val("reopen_edges", n, 4);

        // All zones dry: round-robin order 0,1,2,3,0.
        order.push_back(int'(active_zone));
        prev = valve;
        repeat (60) begin
            cyc(4'b1111, 1'b1);
            if (prev == 0 && valve != 0) order.push_back(int'(active_zone));
            prev = valve;
        end
        check_val("order_count", order.size() >= 5, 1);
        for (int k = 0; k < 5 && k < order.size(); k++)
            check_val("rr_order", order[k], exp_order[k]);

        // Randomized phase.
        rd = 4'hF; re = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < c_ZONES; i++)
                if ($urandom_range(11) == 0) rd[i] = ~rd[i];
            if ($urandom_range(39) == 0) re = ~re;
            if ($urandom_range(399) == 0) async_reset(int'($urandom_range(2)));
            else cyc(rd, re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
